mk14_disp_scan: RTL and testbench

Display refresh scheduler for the MK14 front panel. At a fixed scan rate it reads the eight 7-segment digit slots, and optionally the LED latch, through the MMU display read port. The MMU clears a digit's on-flag after each read, so the block applies software-persistence filtering and drives stable, de-flickered segment and LED outputs to the board display driver.

---
 rtl/mk14_disp_scan.sv | 156 +++++++++++++++
 tb/tb_mk14_disp_scan.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mk14_disp_scan.sv
// MK14 display refresh scheduler: scans the digit slots through the MMU read port and filters flicker.
// Optional LED latch slot enabled by defining DISP_SCAN_LED_EN.
module mk14_disp_scan #(
  parameter int unsigned CLOCK_FREQ_MHZ = 50,
  parameter logic [15:0] DISP_BASE_ADDR = 16'h0D00,
  parameter logic [15:0] LED_BASE_ADDR  = 16'h0D08,
  parameter int unsigned SCAN_PERIOD_US = 1000,
  parameter int unsigned PERSIST_SCANS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        display_read_en,
  output logic [15:0] display_addr,
  input  logic [7:0]  display_data_in,
  output logic [63:0] seg_out,
  output logic [7:0]  digit_valid,
  output logic [7:0]  leds,
  output logic        scan_done
);

  localparam int unsigned PERIOD = CLOCK_FREQ_MHZ * SCAN_PERIOD_US;
  localparam int unsigned PW     = $clog2(PERIOD);
  localparam int unsigned AW     = $clog2(PERSIST_SCANS + 1);

`ifdef DISP_SCAN_LED_EN
  localparam logic [3:0] LAST_SLOT = 4'd8;
`else
  localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      slot_q, slot_d;
  logic [PW-1:0]   presc_q;
  logic            pending_q;
  logic            tick;
  logic [15:0]     slot_addr;
  logic [63:0]     seg_q;
  logic [7:0]      valid_q;
  logic [AW-1:0]   age_q [8];
  logic [2:0]      di;

  assign tick = (presc_q == PW'(PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // A tick during a scan is remembered once and replayed when the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else if (state_q == IDLE) begin
      pending_q <= 1'b0;
    end else if (tick) begin
      pending_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    display_read_en = 1'b0;
    scan_done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick || pending_q) begin
          state_d = ISSUE;
          slot_d  = '0;
        end
      end
      ISSUE: begin
        display_read_en = 1'b1;
        state_d         = CAPTURE;
      end
      CAPTURE: begin
        if (slot_q == LAST_SLOT) begin
          state_d = DONE;
        end else begin
          slot_d  = slot_q + 4'd1;
          state_d = ISSUE;
        end
      end
      DONE: begin
        scan_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot 8 only exists with the LED option, so this mux is inert in the 8-slot build.
  assign slot_addr    = (slot_q == 4'd8) ? LED_BASE_ADDR : (DISP_BASE_ADDR + {13'd0, slot_q[2:0]});
  assign display_addr = display_read_en ? slot_addr : 16'h0000;
  assign di           = slot_q[2:0];

  // The MMU clears on-flags after each read; a digit stays lit until PERSIST_SCANS empty reads in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < 8; i++) begin
        age_q[i] <= AW'(PERSIST_SCANS);
      end
    end else if (state_q == CAPTURE && !slot_q[3]) begin
      if (display_data_in != 8'd0) begin
        seg_q[8*di +: 8] <= display_data_in;
        age_q[di]        <= '0;
        valid_q[di]      <= 1'b1;
      end else if (age_q[di] < AW'(PERSIST_SCANS - 1)) begin
        age_q[di]        <= age_q[di] + AW'(1);
      end else begin
        age_q[di]        <= AW'(PERSIST_SCANS);
        seg_q[8*di +: 8] <= 8'd0;
        valid_q[di]      <= 1'b0;
      end
    end
  end

  assign seg_out     = seg_q;
  assign digit_valid = valid_q;

`ifdef DISP_SCAN_LED_EN
  logic [7:0] leds_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_q <= 8'd0;
    end else if (state_q == CAPTURE && slot_q == 4'd8) begin
      leds_q <= display_data_in;
    end
  end

  assign leds = leds_q;
`else
  assign leds = 8'd0;
`endif

endmodule

// File: tb/tb_mk14_disp_scan.sv
// Directed bench for mk14_disp_scan: a 32-cycle-period instance with an MMU model, plus a
// second instance whose period equals the scan length so a tick lands on DONE.
module tb_mk14_disp_scan;

`ifdef DISP_SCAN_LED_EN
  localparam int NS = 9;
  localparam bit LED_EN = 1'b1;
`else
  localparam int NS = 8;
  localparam bit LED_EN = 1'b0;
`endif
  localparam int PB = 2 * NS + 1;

  logic        clk;
  logic        rst;
  logic        rd_a, rd_b, done_a, done_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic [63:0] seg_a, seg_b;
  logic [7:0]  valid_a, valid_b, leds_a, leds_b;

  logic [7:0]  mem_a [16];
  int          cyc;
  int          total;
  int          bad;
  int          viol;
  logic        prev_rd_a, prev_rd_b;
  logic        exp_rd;
  logic [15:0] exp_addr;
  logic        exp_done;
  int          s0, s1;

  mk14_disp_scan #(
    .CLOCK_FREQ_MHZ(1),
    .DISP_BASE_ADDR(16'h0D00),
    .LED_BASE_ADDR(16'h0D08),
    .SCAN_PERIOD_US(32),
    .PERSIST_SCANS(4)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .display_read_en(rd_a),
    .display_addr(addr_a),
    .display_data_in(data_a),
    .seg_out(seg_a),
    .digit_valid(valid_a),
    .leds(leds_a),
    .scan_done(done_a)
  );

  // Period chosen so the second tick coincides with the DONE cycle of the first scan.
  mk14_disp_scan #(
    .CLOCK_FREQ_MHZ(1),
    .DISP_BASE_ADDR(16'h0D00),
    .LED_BASE_ADDR(16'h0D08),
    .SCAN_PERIOD_US(PB),
    .PERSIST_SCANS(4)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .display_read_en(rd_b),
    .display_addr(addr_b),
    .display_data_in(data_b),
    .seg_out(seg_b),
    .digit_valid(valid_b),
    .leds(leds_b),
    .scan_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // MMU model: registered read data, valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_a && addr_a >= 16'h0D00 && addr_a <= 16'h0D08) data_a <= mem_a[addr_a[3:0]];
    else                                                data_a <= 8'h00;
  end

  // Strobe hygiene across the whole run: no back-to-back strobes, no LED reads without the option.
  always @(negedge clk) begin
    if (rd_a && prev_rd_a) viol <= viol + 1;
    if (rd_b && prev_rd_b) viol <= viol + 1;
    if (!LED_EN && rd_a && addr_a == 16'h0D08) viol <= viol + 1;
    prev_rd_a <= rd_a;
    prev_rd_b <= rd_b;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int slot, input logic [7:0] value);
    mem_a[slot] = value;
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] slotAddr(input int k);
    return (k < 8) ? (16'h0D00 + 16'(k)) : 16'h0D08;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    viol  = 0;
    prev_rd_a = 1'b0;
    prev_rd_b = 1'b0;
    data_b = 8'h00;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_seg", seg_a, 64'h0);
    checkOutput("rst_valid", 64'(valid_a), 64'h0);
    checkOutput("rst_leds", 64'(leds_a), 64'h0);
    checkOutput("rst_rd", 64'(rd_a), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released, idle scan phase");

    s0 = PB;
    s1 = PB + 2 * NS + 2;
    for (int c = 1; c <= s1 + 2 * NS + 1; c++) begin
      waitCycle(c);
      exp_rd = 1'b0;
      exp_addr = 16'h0000;
      if (c >= 32 && c <= 32 + 2 * (NS - 1) && ((c - 32) % 2) == 0) begin
        exp_rd = 1'b1;
        exp_addr = slotAddr((c - 32) / 2);
      end
      checkOutput("a_rd", 64'(rd_a), 64'(exp_rd));
      checkOutput("a_addr", 64'(addr_a), 64'(exp_addr));
      checkOutput("a_done", 64'(done_a), 64'(c == 32 + 2 * NS));
      exp_rd = 1'b0;
      if (c >= s0 && c <= s0 + 2 * (NS - 1) && ((c - s0) % 2) == 0) exp_rd = 1'b1;
      if (c >= s1 && c <= s1 + 2 * (NS - 1) && ((c - s1) % 2) == 0) exp_rd = 1'b1;
      exp_done = (c == s0 + 2 * NS) || (c == s1 + 2 * NS);
      checkOutput("b_rd", 64'(rd_b), 64'(exp_rd));
      checkOutput("b_done", 64'(done_b), 64'(exp_done));
    end
    checkOutput("idle_seg", seg_a, 64'h0);
    checkOutput("idle_valid", 64'(valid_a), 64'h0);
    checkOutput("idle_leds", 64'(leds_a), 64'h0);

    $display("[TB] single-shot digit 2, steady digit 5, LED latch");
    applyStimulus(2, 8'h3F);
    applyStimulus(5, 8'h06);
    applyStimulus(8, 8'hA5);
    waitCycle(69);
    checkOutput("d2_before", 64'(valid_a), 64'h0);
    waitCycle(70);
    checkOutput("d2_seg", 64'(seg_a[23:16]), 64'h3F);
    checkOutput("d2_valid", 64'(valid_a), 64'h04);
    waitCycle(82);
    checkOutput("scan1_seg", seg_a, 64'h0000_0600_003F_0000);
    checkOutput("scan1_valid", 64'(valid_a), 64'h24);
    checkOutput("led_a5", 64'(leds_a), LED_EN ? 64'hA5 : 64'h0);
    applyStimulus(2, 8'h00);
    applyStimulus(8, 8'h00);
    waitCycle(114);
    checkOutput("led_clear", 64'(leds_a), 64'h0);
    checkOutput("d2_hold1", 64'(valid_a), 64'h24);
    waitCycle(197);
    checkOutput("d2_hold3_seg", seg_a, 64'h0000_0600_003F_0000);
    checkOutput("d2_hold3_valid", 64'(valid_a), 64'h24);
    waitCycle(198);
    checkOutput("d2_blank_seg", seg_a, 64'h0000_0600_0000_0000);
    checkOutput("d2_blank_valid", 64'(valid_a), 64'h20);

    $display("[TB] reset during ISSUE of slot 4");
    waitCycle(200);
    applyStimulus(1, 8'h5B);
    waitCycle(228);
    checkOutput("d1_valid", 64'(valid_a), 64'h22);
    checkOutput("d1_seg", 64'(seg_a[15:8]), 64'h5B);
    waitCycle(232);
    checkOutput("slot4_rd", 64'(rd_a), 64'h1);
    checkOutput("slot4_addr", 64'(addr_a), 64'h0D04);
    rst = 1'b1;
    #1;
    checkOutput("abort_rd", 64'(rd_a), 64'h0);
    checkOutput("abort_addr", 64'(addr_a), 64'h0);
    checkOutput("abort_seg", seg_a, 64'h0);
    checkOutput("abort_valid", 64'(valid_a), 64'h0);
    checkOutput("abort_leds", 64'(leds_a), 64'h0);
    checkOutput("abort_done", 64'(done_a), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      waitCycle(c);
      checkOutput("post_rst_rd", 64'(rd_a), 64'(c == 32));
      checkOutput("post_rst_done", 64'(done_a), 64'h0);
    end
    checkOutput("post_rst_addr", 64'(addr_a), 64'h0D00);
    checkOutput("post_rst_valid", 64'(valid_a), 64'h0);

    waitCycle(40);
    checkOutput("strobe_hygiene", 64'(viol), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
